// File: rtl/nbbpu_data_memory.sv
// nbbpu_data_memory: data-memory responder for the NBBPU controller.
// Accepts one read/write per handshake in IDLE, holds it for WAIT_STATES
// cycles, performs the RAM access, then pulses done for one cycle.
// Optional feature macro: NBBPU_DATA_MEMORY_ADDR_CHECK_EN
//   defined   -> RAM is DEPTH words; addresses >= DEPTH flag error,
//                writes are suppressed and reads return 0.
//   undefined -> RAM is 2^ADDR_WIDTH words; error is tied 0.
module nbbpu_data_memory #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Acceptance always enters WAIT, so with zero wait states the access
  // still lands one edge after acceptance (counter starts at 0).
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef NBBPU_DATA_MEMORY_ADDR_CHECK_EN
  localparam int RAM_WORDS = DEPTH;
`else
  localparam int RAM_WORDS = 1 << ADDR_WIDTH;
`endif

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic [3:0]              w_next_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_is_wr;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    w_accept;
  logic                    w_access;
  logic                    w_in_range;

  logic [DATA_WIDTH-1:0]   r_mem [0:RAM_WORDS-1];

  assign w_accept = (r_state == S_IDLE) && (read_enable || write_enable);
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef NBBPU_DATA_MEMORY_ADDR_CHECK_EN
  logic r_err;

  assign w_in_range = (32'(r_addr) < 32'(DEPTH));

  // Out-of-range flag captured on the access edge, shown only during DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_err <= 1'b0;
    else if (w_access) r_err <= !w_in_range;
  end

  assign error = (r_state == S_DONE) && r_err;
`else
  assign w_in_range = 1'b1;
  assign error      = 1'b0;
`endif

  // State and wait counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic: IDLE -> WAIT on request, WAIT counts down, DONE lasts one cycle
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
          w_next_cnt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next_state = S_DONE;
        else               w_next_cnt   = r_cnt - 4'd1;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request capture at acceptance; write wins over a simultaneous read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= address;
      r_wdata <= write_data;
      r_is_wr <= write_enable;
    end
  end

  // RAM write on the access edge; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (w_access && r_is_wr && w_in_range) r_mem[r_addr] <= r_wdata;
  end

  // Read data register: only a completed read changes it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (w_access && !r_is_wr) begin
      r_rdata <= w_in_range ? r_mem[r_addr] : '0;
    end
  end

  assign read_data = r_rdata;
  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
